inertial_interface: RTL
=======================

Name: inertial_interface

Overview:
- SPI master front-end for the 6-axis inertial sensor (gyro + accel). It feeds the pitch integrator.
- After reset it configures the sensor with a fixed four-write init sequence.
- On each sensor data-ready interrupt (INT) it reads pitch rate and Z acceleration as byte pairs, then presents 16-bit ptch_rt and AZ with a one-cycle vld strobe.

Parameters:
- INIT_WAIT_BITS, 16, width of the post-reset settle counter; init starts when the counter reaches all-ones.
- SCLK_DIV_BITS, 4, SCLK period in clk cycles = 2^SCLK_DIV_BITS.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- INT  input  1  sensor data-ready interrupt, asynchronous, active high
- MISO  input  1  SPI serial data from sensor
- SS_n  output  1  SPI slave select, active low
- SCLK  output  1  SPI clock, idles high
- MOSI  output  1  SPI serial data to sensor
- vld  output  1  one-cycle pulse: new ptch_rt/AZ available
- ptch_rt  output  16  raw signed pitch rate {high byte, low byte}
- AZ  output  16  raw signed Z acceleration {high byte, low byte}

Behaviour:
- Reset values: vld=0, ptch_rt=0, AZ=0, SS_n=1, SCLK=1, MOSI=0. The settle counter and FSM also reset (FSM to INIT_WAIT).
- Reset asserted mid-transaction aborts it immediately. SS_n=1 with the same asynchronous timing.
- SPI transaction (sub-module):
  - 16-bit, mode 3, MSB first.
  - cmd[15:8]: bit15=1 read / 0 write, bits14:8 register address. cmd[7:0]: write data, or don't-care for reads.
  - wrt is a 1-cycle pulse that is ignored while busy.
  - done pulses 1 cycle after SS_n deasserts.
  - Read data is rd_data[7:0].
- INT is double-flop synchronized. Only the synchronized level is used.
- FSM states and transitions:
  - INIT_WAIT: settle counter increments every clk. At all-ones, go to INIT1.
  - INIT1..INIT4: issue one write each. Pulse wrt on state entry, then advance when done arrives. Commands in order:
    - 0x0D02: INT on data ready
    - 0x1053: accel 208Hz, +/-2g
    - 0x1150: gyro 208Hz, 250dps
    - 0x1460: rounding on
  - WAIT_INT: idle until synchronized INT=1.
  - RD_PL: read cmd 0xA2xx; capture pitch low byte.
  - RD_PH: read cmd 0xA3xx; capture pitch high byte.
  - RD_AL: read cmd 0xACxx; capture AZ low byte.
  - RD_AH: read cmd 0xADxx; capture AZ high byte.
  - Each read state captures rd_data[7:0] into a holding register on done.
  - After RD_AH's done: the next cycle loads ptch_rt and AZ from the holding registers and pulses vld for exactly that cycle, then returns to WAIT_INT.
- ptch_rt/AZ change only in the vld cycle. They hold between updates.
- INT still high on return to WAIT_INT (sensor not yet cleared) starts another read set. The sensor clears INT on read of the high bytes.
- INT asserting during INIT or a read set has no effect until WAIT_INT is reached. No event queueing.
- MISO sampled on SCLK rising edge, MOSI shifted on falling edge.
- SS_n low one half-SCLK before the first edge and held one half-SCLK after the last edge.
- Latency from INT rise to vld: 2 sync cycles + 4 transactions + 1 cycle. Expect about 4*(16*16+overhead) clk.

Decomposition:
- Shared package: state enum for the FSM; localparams for the four init commands and the four read-address commands.
- One sub-module, SPI_mnrch: generic 16-bit SPI master.
  - Ports: clk, rst_n, wrt, cmd[15:0], done, rd_data[15:0], SS_n, SCLK, MOSI, MISO.
  - Parameter: SCLK_DIV_BITS.
  - The top level contains only the settle counter, INT synchronizer, FSM, and byte holding registers.

Test Plan:
- Use a bench SPI sensor model that logs writes and returns programmed register contents.
- Reset release with INIT_WAIT_BITS=4 for sim -> after 15 clk, model logs writes 0x0D02, 0x1053, 0x1150, 0x1460 in order. No vld before INT.
- Regs 0x22=0x34, 0x23=0x12, 0x2C=0x80, 0x2D=0xFE; INT pulse -> exactly one vld. At vld, ptch_rt=0x1234 and AZ=0xFE80; values hold afterwards.
- INT held high through two read sets, second set 0x22=0xFF, 0x23=0x7F -> two vld pulses; second ptch_rt=0x7FFF.
- INT asserted during INIT2 -> no reads until INIT4 completes. The read set then starts from WAIT_INT.
- rst_n low in the middle of RD_AL -> SS_n=1, vld=0, ptch_rt=AZ=0 asynchronously. After release, the full init sequence repeats.
- Check every transaction: SCLK idle high, 16 SCLK periods of 16 clk each, MOSI stable at each rising SCLK edge.

Source files
------------

// File: rtl/inertial_interface_pkg.sv
`default_nettype none
// ============================================================================
// Package  : inertial_interface_pkg
// Brief    : Shared types and command words for the inertial sensor
//            front-end (top-level FSM states, SPI master states, init
//            write commands and read-address commands).
// Revision : 1.0 - initial release
// ============================================================================
package inertial_interface_pkg;

    // Top-level sequencing: power-up settle, four config writes, then
    // an interrupt-driven four-byte read loop.
    typedef enum logic [3:0] {
        ST_INIT_WAIT = 4'd0,
        ST_INIT1     = 4'd1,
        ST_INIT2     = 4'd2,
        ST_INIT3     = 4'd3,
        ST_INIT4     = 4'd4,
        ST_WAIT_INT  = 4'd5,
        ST_RD_PL     = 4'd6,
        ST_RD_PH     = 4'd7,
        ST_RD_AL     = 4'd8,
        ST_RD_AH     = 4'd9
    } state_t;

    // SPI master phases: front porch, SCLK low half, SCLK high half,
    // and the one-cycle done strobe after SS_n is released.
    typedef enum logic [2:0] {
        SPI_IDLE  = 3'd0,
        SPI_FRONT = 3'd1,
        SPI_LOW   = 3'd2,
        SPI_HIGH  = 3'd3,
        SPI_DONE  = 3'd4
    } spi_state_t;

    // Sensor configuration writes, issued in this order after settle.
    localparam logic [15:0] c_init_cmd1 = 16'h0D02; // INT on data ready
    localparam logic [15:0] c_init_cmd2 = 16'h1053; // accel 208Hz, +/-2g
    localparam logic [15:0] c_init_cmd3 = 16'h1150; // gyro 208Hz, 250dps
    localparam logic [15:0] c_init_cmd4 = 16'h1460; // rounding on

    // Data reads: bit15 set selects read, low byte is don't-care.
    localparam logic [15:0] c_rd_pl_cmd = 16'hA200; // pitch rate low
    localparam logic [15:0] c_rd_ph_cmd = 16'hA300; // pitch rate high
    localparam logic [15:0] c_rd_al_cmd = 16'hAC00; // Z accel low
    localparam logic [15:0] c_rd_ah_cmd = 16'hAD00; // Z accel high

endpackage
`default_nettype wire

// File: rtl/inertial_interface_spi_mnrch.sv
`default_nettype none
// ============================================================================
// Module   : SPI_mnrch
// Brief    : Generic 16-bit SPI master, mode 3 (SCLK idles high, MOSI
//            changes on falling edge, MISO sampled on rising edge), MSB
//            first. SCLK period is 2^SCLK_DIV_BITS clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
module SPI_mnrch #(
    parameter int SCLK_DIV_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);
    import inertial_interface_pkg::*;

    // Half-period counter: wraps naturally after 2^(SCLK_DIV_BITS-1) clks.
    localparam int                     c_half_w    = SCLK_DIV_BITS - 1;
    localparam logic [c_half_w-1:0]    c_half_last = '1;
    localparam logic [c_half_w-1:0]    c_half_one  = {{(c_half_w-1){1'b0}}, 1'b1};

    spi_state_t          r_state;
    logic [c_half_w-1:0] r_div;
    logic [4:0]          r_bit_cnt;
    logic [15:0]         r_shft;
    logic                r_miso_smpl;
    logic                r_sclk;
    logic                r_ss_n;
    logic                r_done;
    logic                w_half_end;

    assign w_half_end = (r_div == c_half_last);

    // The command shifts out of the top while response bits enter at the
    // bottom, so after 16 bits the same register holds the read data.
    assign MOSI    = r_shft[15];
    assign rd_data = r_shft;
    assign SCLK    = r_sclk;
    assign SS_n    = r_ss_n;
    assign done    = r_done;

    // Transaction sequencer: porch, 16 low/high SCLK halves, release, done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SPI_IDLE;
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_shft      <= '0;
            r_miso_smpl <= 1'b0;
            r_sclk      <= 1'b1;
            r_ss_n      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                SPI_IDLE: begin
                    if (wrt) begin
                        r_shft    <= cmd;
                        r_ss_n    <= 1'b0;
                        r_div     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= SPI_FRONT;
                    end
                end
                // MSB is already on MOSI; wait half a period before the
                // first falling edge.
                SPI_FRONT: begin
                    r_div <= r_div + c_half_one;
                    if (w_half_end) begin
                        r_sclk  <= 1'b0;
                        r_state <= SPI_LOW;
                    end
                end
                SPI_LOW: begin
                    r_div <= r_div + c_half_one;
                    if (w_half_end) begin
                        r_sclk      <= 1'b1;
                        r_miso_smpl <= MISO;
                        r_bit_cnt   <= r_bit_cnt + 5'd1;
                        r_state     <= SPI_HIGH;
                    end
                end
                // End of each high half: shift (this is the falling edge
                // moment), or after the 16th bit release SS_n instead of
                // dropping SCLK again.
                SPI_HIGH: begin
                    r_div <= r_div + c_half_one;
                    if (w_half_end) begin
                        r_shft <= {r_shft[14:0], r_miso_smpl};
                        if (r_bit_cnt == 5'd16) begin
                            r_ss_n  <= 1'b1;
                            r_state <= SPI_DONE;
                        end else begin
                            r_sclk  <= 1'b0;
                            r_state <= SPI_LOW;
                        end
                    end
                end
                SPI_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= SPI_IDLE;
                end
                default: r_state <= SPI_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/inertial_interface.sv
`default_nettype none
// ============================================================================
// Module   : inertial_interface
// Brief    : SPI front-end for the 6-axis inertial sensor. Configures the
//            sensor after a settle delay, then on each data-ready interrupt
//            reads pitch rate and Z acceleration and presents them with a
//            one-cycle vld strobe.
// Revision : 1.0 - initial release
// ============================================================================
module inertial_interface #(
    parameter int INIT_WAIT_BITS = 16,
    parameter int SCLK_DIV_BITS  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);
    import inertial_interface_pkg::*;

    localparam logic [INIT_WAIT_BITS-1:0] c_settle_one = {{(INIT_WAIT_BITS-1){1'b0}}, 1'b1};

    state_t                    r_state;
    logic [INIT_WAIT_BITS-1:0] r_settle;
    logic                      r_int_ff1;
    logic                      r_int_sync;
    logic                      r_wrt;
    logic [15:0]               r_cmd;
    logic [7:0]                r_pl;
    logic [7:0]                r_ph;
    logic [7:0]                r_al;
    logic                      r_vld;
    logic [15:0]               r_ptch_rt;
    logic [15:0]               r_az;
    logic                      w_done;
    logic [15:0]               w_rd_data;
    logic [7:0]                w_unused_rd_hi;

    // Upper byte is what the sensor drove while the command was shifting.
    assign w_unused_rd_hi = w_rd_data[15:8];

    assign vld     = r_vld;
    assign ptch_rt = r_ptch_rt;
    assign AZ      = r_az;

    SPI_mnrch #(
        .SCLK_DIV_BITS (SCLK_DIV_BITS)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (r_wrt),
        .cmd     (r_cmd),
        .done    (w_done),
        .rd_data (w_rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    // Two-flop synchronizer for the asynchronous sensor interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_ff1  <= 1'b0;
            r_int_sync <= 1'b0;
        end else begin
            r_int_ff1  <= INT;
            r_int_sync <= r_int_ff1;
        end
    end

    // Post-reset settle counter; runs only while waiting to configure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
        end else if (r_state == ST_INIT_WAIT) begin
            r_settle <= r_settle + c_settle_one;
        end
    end

    // Main sequencer: wrt is pulsed on entry to each transaction state and
    // the state advances on the SPI done strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT_WAIT;
            r_wrt     <= 1'b0;
            r_cmd     <= '0;
            r_pl      <= '0;
            r_ph      <= '0;
            r_al      <= '0;
            r_vld     <= 1'b0;
            r_ptch_rt <= '0;
            r_az      <= '0;
        end else begin
            r_wrt <= 1'b0;
            r_vld <= 1'b0;
            case (r_state)
                ST_INIT_WAIT: begin
                    if (&r_settle) begin
                        r_state <= ST_INIT1;
                        r_wrt   <= 1'b1;
                        r_cmd   <= c_init_cmd1;
                    end
                end
                ST_INIT1: begin
                    if (w_done) begin
                        r_state <= ST_INIT2;
                        r_wrt   <= 1'b1;
                        r_cmd   <= c_init_cmd2;
                    end
                end
                ST_INIT2: begin
                    if (w_done) begin
                        r_state <= ST_INIT3;
                        r_wrt   <= 1'b1;
                        r_cmd   <= c_init_cmd3;
                    end
                end
                ST_INIT3: begin
                    if (w_done) begin
                        r_state <= ST_INIT4;
                        r_wrt   <= 1'b1;
                        r_cmd   <= c_init_cmd4;
                    end
                end
                ST_INIT4: begin
                    if (w_done) begin
                        r_state <= ST_WAIT_INT;
                    end
                end
                ST_WAIT_INT: begin
                    if (r_int_sync) begin
                        r_state <= ST_RD_PL;
                        r_wrt   <= 1'b1;
                        r_cmd   <= c_rd_pl_cmd;
                    end
                end
                ST_RD_PL: begin
                    if (w_done) begin
                        r_pl    <= w_rd_data[7:0];
                        r_state <= ST_RD_PH;
                        r_wrt   <= 1'b1;
                        r_cmd   <= c_rd_ph_cmd;
                    end
                end
                ST_RD_PH: begin
                    if (w_done) begin
                        r_ph    <= w_rd_data[7:0];
                        r_state <= ST_RD_AL;
                        r_wrt   <= 1'b1;
                        r_cmd   <= c_rd_al_cmd;
                    end
                end
                ST_RD_AL: begin
                    if (w_done) begin
                        r_al    <= w_rd_data[7:0];
                        r_state <= ST_RD_AH;
                        r_wrt   <= 1'b1;
                        r_cmd   <= c_rd_ah_cmd;
                    end
                end
                // The AZ high byte goes straight from the SPI data into the
                // output register, so both words appear together with vld
                // in the cycle after the final done.
                ST_RD_AH: begin
                    if (w_done) begin
                        r_ptch_rt <= {r_ph, r_pl};
                        r_az      <= {w_rd_data[7:0], r_al};
                        r_vld     <= 1'b1;
                        r_state   <= ST_WAIT_INT;
                    end
                end
                default: r_state <= ST_INIT_WAIT;
            endcase
        end
    end

endmodule
`default_nettype wire
